// File: rtl/uart_tx_pkg.sv
// Shared constants for the data-memory-mapped UART transmitter.
// Register offsets, STATUS bit positions, FSM encoding and 8N1 frame shape.
package uart_tx_pkg;

  localparam logic [1:0] REG_TXDATA  = 2'd0;
  localparam logic [1:0] REG_STATUS  = 2'd1;
  localparam logic [1:0] REG_BAUDDIV = 2'd2;
  localparam logic [1:0] REG_CTRL    = 2'd3;

  localparam int ST_BUSY_BIT  = 0;
  localparam int ST_FULL_BIT  = 1;
  localparam int ST_EMPTY_BIT = 2;
  localparam int ST_OVF_BIT   = 3;
  localparam int ST_COUNT_LSB = 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } tx_state_t;

  localparam int DATA_BITS = 8;
  localparam int STOP_BITS = 1;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO, combinational read of the head entry, no internal overflow guard beyond full.
// Push while full and pop while empty are ignored; count has one extra bit so DEPTH is representable.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  // Pointers carry one wrap bit so full and empty differ without a separate flag.
  assign count = wr_ptr - rd_ptr;
  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (wr_ptr == rd_ptr);
  assign dout  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full)  wr_ptr <= wr_ptr + 1'b1;
      if (pop  && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/dm_uart_tx.sv
// Data-memory-bus UART transmitter: TX FIFO feeding an 8N1 serialiser; reads return one cycle after access.
// Bytes written to a full FIFO are dropped and flag a sticky overflow; o_tx and o_busy are registered.
module dm_uart_tx
  import uart_tx_pkg::*;
#(
  parameter int          FIFO_DEPTH  = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd433
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [63:0] i_dm_addr,
  input  logic        i_dm_cs,
  input  logic        i_dm_rw,
  input  logic [63:0] i_dm_data,
  output logic [63:0] o_dm_data,
  output logic        o_tx,
  output logic        o_busy
);

  localparam int          CW        = $clog2(FIFO_DEPTH) + 1;
  localparam logic [2:0]  LAST_DATA = 3'(DATA_BITS - 1);
  localparam logic [2:0]  LAST_STOP = 3'(STOP_BITS - 1);

  logic [1:0]    reg_sel;
  logic          wr_en;
  logic          rd_en;
  logic          push_req;
  logic          pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic [7:0]    fifo_dout;
  logic [CW-1:0] fifo_count;
  logic [15:0]   bauddiv;
  logic [15:0]   baud_cnt;
  logic          en;
  logic          overflow;
  tx_state_t     state;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          bit_end;
  logic          busy_now;
  logic          tx_next;
  logic [63:0]   status;
  logic [63:0]   rdata;
  logic          unused_bits;

  assign reg_sel     = i_dm_addr[4:3];
  assign wr_en       = i_dm_cs & i_dm_rw;
  assign rd_en       = i_dm_cs & ~i_dm_rw;
  assign push_req    = wr_en && (reg_sel == REG_TXDATA);
  assign bit_end     = (baud_cnt == 16'd0);
  assign busy_now    = (state != S_IDLE) || !fifo_empty;
  assign unused_bits = ^{i_dm_addr[63:5], i_dm_addr[2:0], i_dm_data[63:16]};

  // A new frame starts from IDLE or straight out of the last stop bit, never mid-frame.
  assign pop = en && !fifo_empty &&
               ((state == S_IDLE) ||
                (state == S_STOP && bit_end && bit_idx == LAST_STOP));

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .push  (push_req),
    .pop   (pop),
    .din   (i_dm_data[7:0]),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    status                       = '0;
    status[ST_BUSY_BIT]          = busy_now;
    status[ST_FULL_BIT]          = fifo_full;
    status[ST_EMPTY_BIT]         = fifo_empty;
    status[ST_OVF_BIT]           = overflow;
    status[ST_COUNT_LSB +: 8]    = 8'(fifo_count);
  end

  always_comb begin
    rdata = '0;
    case (reg_sel)
      REG_STATUS:  rdata = status;
      REG_BAUDDIV: rdata[15:0] = bauddiv;
      REG_CTRL:    rdata[0] = en;
      default:     rdata = '0;
    endcase
  end

  always_comb begin
    case (state)
      S_START: tx_next = 1'b0;
      S_DATA:  tx_next = shreg[0];
      default: tx_next = 1'b1;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      bauddiv   <= DEFAULT_DIV;
      en        <= 1'b0;
      overflow  <= 1'b0;
      o_dm_data <= '0;
    end else begin
      if (wr_en && reg_sel == REG_BAUDDIV) bauddiv <= i_dm_data[15:0];
      if (wr_en && reg_sel == REG_CTRL)    en      <= i_dm_data[0];
      // Dropped byte takes priority over a same-cycle write-1-to-clear.
      if (push_req && fifo_full)
        overflow <= 1'b1;
      else if (wr_en && reg_sel == REG_STATUS && i_dm_data[ST_OVF_BIT])
        overflow <= 1'b0;
      if (rd_en) o_dm_data <= rdata;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= S_IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      o_tx     <= 1'b1;
      o_busy   <= 1'b0;
    end else begin
      o_tx   <= tx_next;
      o_busy <= busy_now;
      case (state)
        S_IDLE: begin
          if (pop) begin
            shreg    <= fifo_dout;
            baud_cnt <= bauddiv;
            state    <= S_START;
          end
        end
        S_START: begin
          if (bit_end) begin
            baud_cnt <= bauddiv;
            bit_idx  <= '0;
            state    <= S_DATA;
          end else begin
            baud_cnt <= baud_cnt - 16'd1;
          end
        end
        S_DATA: begin
          if (bit_end) begin
            baud_cnt <= bauddiv;
            shreg    <= shreg >> 1;
            if (bit_idx == LAST_DATA) begin
              bit_idx <= '0;
              state   <= S_STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            baud_cnt <= baud_cnt - 16'd1;
          end
        end
        default: begin
          if (bit_end) begin
            baud_cnt <= bauddiv;
            if (bit_idx != LAST_STOP) begin
              bit_idx <= bit_idx + 3'd1;
            end else if (pop) begin
              shreg <= fifo_dout;
              state <= S_START;
            end else begin
              state <= S_IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt - 16'd1;
          end
        end
      endcase
    end
  end

endmodule
